// File: rtl/arbitrated_fifo_pkg.sv
// arbitrated_fifo_pkg: shared width helpers and pointer wrap for the FIFO bank
package arbitrated_fifo_pkg;
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
  function automatic int tagwidth(input int n);
    return clog2_min1(n);
  endfunction
  function automatic int cntwidth(input int depth);
    return clog2_min1(depth + 1);
  endfunction
  function automatic int ptr_inc(input int ptr, input int m);
    return (ptr + 1 >= m) ? 0 : ptr + 1;
  endfunction
endpackage

// File: rtl/circular_pointer_fifo.sv
// circular_pointer_fifo: first-word fall-through circular FIFO, any depth >= 2
module circular_pointer_fifo import arbitrated_fifo_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int PW = clog2_min1(DEPTH);
  localparam int CW = cntwidth(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic wr, rd;
  assign full  = count == CW'(DEPTH);
  assign empty = count == '0;
  assign wr    = push & ~full;
  assign rd    = pop & ~empty;
  assign dout  = mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr) begin
        mem[wr_ptr] <= din;
        wr_ptr <= PW'(ptr_inc(int'(wr_ptr), DEPTH));
      end
      if (rd) rd_ptr <= PW'(ptr_inc(int'(rd_ptr), DEPTH));
      count <= count + CW'(wr) - CW'(rd);
    end
  end
endmodule

// File: rtl/round_robin_arbiter.sv
// round_robin_arbiter: one-hot grant scanning upward from rr_ptr, wrapping
module round_robin_arbiter import arbitrated_fifo_pkg::*; #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] req,
  output logic [WIDTH-1:0] gnt
);
  localparam int PW = tagwidth(WIDTH);
  logic [PW-1:0] rr_ptr, g_idx;
  logic hit;
  int j;
  // descending scan so the request nearest rr_ptr is the last (winning) hit
  always_comb begin
    hit = 1'b0;
    g_idx = '0;
    j = 0;
    for (int k = WIDTH - 1; k >= 0; k--) begin
      j = int'(rr_ptr) + k;
      j = (j >= WIDTH) ? j - WIDTH : j;
      if (req[j]) begin
        hit = 1'b1;
        g_idx = PW'(j);
      end
    end
    gnt = (hit && !rst) ? WIDTH'(1) << g_idx : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) rr_ptr <= '0;
    else if (hit) rr_ptr <= PW'(ptr_inc(int'(g_idx), WIDTH));
  end
endmodule

// File: rtl/arbitrated_fifo_bank.sv
// arbitrated_fifo_bank: tagged FIFO bank with push redirect and round-robin pop
module arbitrated_fifo_bank import arbitrated_fifo_pkg::*; #(
  parameter int NUM_FIFOS = 4,
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int REDIRECT  = 1,
  localparam int TAGWIDTH = tagwidth(NUM_FIFOS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic [TAGWIDTH-1:0]  push_sel,
  input  logic [WIDTH-1:0]     data_in,
  output logic                 push_ack,
  output logic [TAGWIDTH-1:0]  push_dest,
  input  logic [NUM_FIFOS-1:0] reqs,
  output logic [NUM_FIFOS-1:0] gnt,
  output logic [WIDTH-1:0]     data_out,
  output logic [TAGWIDTH-1:0]  data_out_tag,
  output logic                 data_out_vld,
  output logic [NUM_FIFOS-1:0] full,
  output logic [NUM_FIFOS-1:0] empty
);
  localparam int DW = WIDTH + TAGWIDTH;
  logic [DW-1:0] head [NUM_FIFOS];
  logic [DW-1:0] dmux;
  logic [NUM_FIFOS-1:0] fifo_push;
  int idx;
  round_robin_arbiter #(.WIDTH(NUM_FIFOS)) u_arb (
    .clk(clk), .rst(rst), .req(reqs & ~empty), .gnt(gnt)
  );
  for (genvar i = 0; i < NUM_FIFOS; i++) begin : g_fifo
    assign fifo_push[i] = push_ack && push_dest == TAGWIDTH'(i);
    circular_pointer_fifo #(.WIDTH(DW), .DEPTH(DEPTH)) u_fifo (
      .clk(clk), .rst(rst), .push(fifo_push[i]), .pop(gnt[i]),
      .din({push_sel, data_in}), .dout(head[i]), .full(full[i]), .empty(empty[i])
    );
  end
  // descending scan: the own channel (k=0) wins, else the nearest non-full successor
  always_comb begin
    push_ack = 1'b0;
    push_dest = '0;
    idx = 0;
    for (int k = NUM_FIFOS - 1; k >= 0; k--) begin
      idx = int'(push_sel) + k;
      idx = (idx >= NUM_FIFOS) ? idx - NUM_FIFOS : idx;
      if ((k == 0 || REDIRECT != 0) && idx < NUM_FIFOS && !full[idx]) begin
        push_ack = 1'b1;
        push_dest = TAGWIDTH'(idx);
      end
    end
    if (!push || rst || int'(push_sel) >= NUM_FIFOS) push_ack = 1'b0;
  end
  always_comb begin
    dmux = '0;
    for (int i = 0; i < NUM_FIFOS; i++) dmux = dmux | (gnt[i] ? head[i] : '0);
  end
  assign data_out     = dmux[WIDTH-1:0];
  assign data_out_tag = dmux[DW-1:WIDTH];
  assign data_out_vld = |gnt;
endmodule

// File: tb/tb_arbitrated_fifo_bank.sv
// tb_arbitrated_fifo_bank: random traffic on redirect and drop variants vs queue model
module tb_arbitrated_fifo_bank;
  localparam int N = 4, W = 8, D = 4, TW = 2;
  logic clk = 1'b0, rst, push;
  logic [TW-1:0] push_sel;
  logic [W-1:0] data_in;
  logic [N-1:0] reqs;
  logic ack [2];
  logic [TW-1:0] dest [2];
  logic [N-1:0] gnt [2], full [2], empty [2];
  logic [W-1:0] dout [2];
  logic [TW-1:0] dtag [2];
  logic vld [2];
  logic [TW+W-1:0] q [2][N][$];
  int rr [2], ea [2], ed [2], eg [2];
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  arbitrated_fifo_bank #(.NUM_FIFOS(N), .WIDTH(W), .DEPTH(D), .REDIRECT(0)) dut0 (
    .clk(clk), .rst(rst), .push(push), .push_sel(push_sel), .data_in(data_in),
    .push_ack(ack[0]), .push_dest(dest[0]), .reqs(reqs), .gnt(gnt[0]), .data_out(dout[0]),
    .data_out_tag(dtag[0]), .data_out_vld(vld[0]), .full(full[0]), .empty(empty[0])
  );
  arbitrated_fifo_bank #(.NUM_FIFOS(N), .WIDTH(W), .DEPTH(D), .REDIRECT(1)) dut1 (
    .clk(clk), .rst(rst), .push(push), .push_sel(push_sel), .data_in(data_in),
    .push_ack(ack[1]), .push_dest(dest[1]), .reqs(reqs), .gnt(gnt[1]), .data_out(dout[1]),
    .data_out_tag(dtag[1]), .data_out_vld(vld[1]), .full(full[1]), .empty(empty[1])
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic check_model(input int m);
    logic [N-1:0] ef, ee;
    logic [TW+W-1:0] h;
    int sel, j;
    sel = int'(push_sel);
    ea[m] = 0; ed[m] = 0; eg[m] = -1;
    for (int i = 0; i < N; i++) begin
      ef[i] = q[m][i].size() == D;
      ee[i] = q[m][i].size() == 0;
    end
    if (!rst && push) begin
      if (q[m][sel].size() < D) begin
        ea[m] = 1; ed[m] = sel;
      end else if (m == 1) begin
        for (int k = 1; k < N; k++) begin
          j = (sel + k) % N;
          if (ea[m] == 0 && q[m][j].size() < D) begin
            ea[m] = 1; ed[m] = j;
          end
        end
      end
    end
    if (!rst)
      for (int k = 0; k < N; k++) begin
        j = (rr[m] + k) % N;
        if (eg[m] < 0 && reqs[j] && q[m][j].size() > 0) eg[m] = j;
      end
    h = (eg[m] >= 0) ? q[m][eg[m]][0] : '0;
    chk($sformatf("full%0d", m), 32'(full[m]), 32'(ef));
    chk($sformatf("empty%0d", m), 32'(empty[m]), 32'(ee));
    chk($sformatf("ack%0d", m), 32'(ack[m]), 32'(ea[m]));
    if (ea[m] != 0) chk($sformatf("dest%0d", m), 32'(dest[m]), 32'(ed[m]));
    chk($sformatf("gnt%0d", m), 32'(gnt[m]), (eg[m] < 0) ? 32'd0 : 32'd1 << eg[m]);
    chk($sformatf("dout%0d", m), 32'(dout[m]), 32'(h[W-1:0]));
    chk($sformatf("tag%0d", m), 32'(dtag[m]), 32'(h[TW+W-1:W]));
    chk($sformatf("vld%0d", m), 32'(vld[m]), 32'(eg[m] >= 0));
  endtask
  task automatic update_model(input int m);
    if (rst) begin
      for (int i = 0; i < N; i++) q[m][i].delete();
      rr[m] = 0;
    end else begin
      if (eg[m] >= 0) begin
        void'(q[m][eg[m]].pop_front());
        rr[m] = (eg[m] + 1) % N;
      end
      if (ea[m] != 0) q[m][ed[m]].push_back({push_sel, data_in});
    end
  endtask
  initial begin
    int phase, pp, rp;
    rst = 1'b1; push = 1'b0; push_sel = '0; data_in = '0; reqs = '0;
    rr[0] = 0; rr[1] = 0;
    @(posedge clk);
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      phase = (c / 40) % 4;
      pp = (phase == 0) ? 9 : (phase == 2) ? 1 : 5;
      rp = (phase == 0) ? 1 : (phase == 2) ? 7 : 4;
      rst = (c < 2) || ($urandom_range(0, 99) == 0);
      push = $urandom_range(0, 9) < pp;
      push_sel = TW'($urandom_range(0, N - 1));
      data_in = W'($urandom);
      for (int i = 0; i < N; i++) reqs[i] = $urandom_range(0, 9) < rp;
      #1;
      check_model(0);
      check_model(1);
      @(posedge clk);
      update_model(0);
      update_model(1);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
